// File: rtl/open_list_pkg.sv
// Shared types and width helpers for the A* open-list priority queue.
package open_list_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REP_SEARCH = 2'd1,
      REP_INSERT = 2'd2
   } rep_state_e;

   function automatic int coord_w(input int extent);
      return (extent > 1) ? $clog2(extent) : 1;
   endfunction

   function automatic int xy_w(input int map_width, input int map_height);
      return coord_w(map_width) + coord_w(map_height);
   endfunction

endpackage

// File: rtl/open_list_pq_slot.sv
// One storage slot of the sorted open list: {valid, f, xy} with load/shift controls
// and local compare results against the current search key.
module open_list_pq_slot #(
   parameter int DATA_WIDTH = 32,
   parameter int XY_W       = 8
) (
   input  logic                       CLK,
   input  logic                       RSTn,
   input  logic                       load_i,
   input  logic                       shift_up_i,
   input  logic                       shift_down_i,
   input  logic [DATA_WIDTH+XY_W:0]   new_i,
   input  logic [DATA_WIDTH+XY_W:0]   up_i,
   input  logic [DATA_WIDTH+XY_W:0]   down_i,
   input  logic [DATA_WIDTH-1:0]      key_f_i,
   input  logic [XY_W-1:0]            key_xy_i,
   output logic [DATA_WIDTH+XY_W:0]   entry_o,
   output logic                       le_o,
   output logic                       match_o
);

   logic [DATA_WIDTH+XY_W:0] entry_q, entry_d;
   logic                     valid_s;
   logic [DATA_WIDTH-1:0]    f_s;
   logic [XY_W-1:0]          xy_s;

   // Slot next-state select: load wins over shifts.
   always_comb begin
      entry_d = entry_q;
      if (load_i) begin
         entry_d = new_i;
      end else if (shift_up_i) begin
         entry_d = up_i;
      end else if (shift_down_i) begin
         entry_d = down_i;
      end else begin
         entry_d = entry_q;
      end
   end

   // Slot storage register.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign valid_s = entry_q[DATA_WIDTH+XY_W];
   assign f_s     = entry_q[DATA_WIDTH+XY_W-1:XY_W];
   assign xy_s    = entry_q[XY_W-1:0];
   assign entry_o = entry_q;
   assign le_o    = valid_s && (f_s <= key_f_i);
   assign match_o = valid_s && (xy_s == key_xy_i);

endmodule

// File: rtl/open_list_pq.sv
// A* open-list min-priority queue: sorted slot array with FIFO ties, pop-and-push,
// and a two-cycle decrease-key replace keyed by map coordinate.
module open_list_pq
   import open_list_pkg::*;
#(
   parameter int QUEUE_SIZE = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAP_WIDTH  = 16,
   parameter int MAP_HEIGHT = 16
) (
   input  logic                                       CLK,
   input  logic                                       RSTn,
   input  logic                                       i_valid,
   input  logic                                       i_wrt,
   input  logic                                       i_read,
   input  logic                                       i_rep,
   input  logic [DATA_WIDTH-1:0]                      i_node_f,
   input  logic [xy_w(MAP_WIDTH, MAP_HEIGHT)-1:0]     i_node_xy,
   output logic                                       o_ready_enq,
   output logic                                       o_ready_deq,
   output logic                                       o_ready_rep,
   output logic                                       o_full,
   output logic                                       o_empty,
   output logic                                       o_valid,
   output logic [DATA_WIDTH-1:0]                      o_node_f,
   output logic [xy_w(MAP_WIDTH, MAP_HEIGHT)-1:0]     o_node_xy,
   output logic [$clog2(QUEUE_SIZE+1)-1:0]            o_count,
   output logic                                       o_overflow
);

   localparam int N    = QUEUE_SIZE;
   localparam int XY_W = xy_w(MAP_WIDTH, MAP_HEIGHT);
   localparam int EW   = 1 + DATA_WIDTH + XY_W;
   localparam int CW   = $clog2(QUEUE_SIZE + 1);

   rep_state_e             state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic [DATA_WIDTH-1:0]  rep_f_q, rep_f_d;
   logic [XY_W-1:0]        rep_xy_q, rep_xy_d;
   logic                   rep_ins_q, rep_ins_d;
   logic                   ovf_q, ovf_d;

   logic [EW-1:0]          ent_s [N];
   logic [N-1:0]           le_s, match_s, le_nx_s, pos_s, after_s, pp_pos_s, rm_s, rm_ge_s;
   logic [N-1:0]           load_s, sup_s, sdn_s;
   logic [DATA_WIDTH-1:0]  key_f_s;
   logic [EW-1:0]          new_e_s;
   logic                   idle_s, full_s, empty_s, rm_do_s, any_match_s;
   logic                   acc_wrt_s, acc_read_s, acc_pp_s, acc_rep_s;

   assign idle_s  = (state_q == IDLE);
   assign full_s  = (count_q == CW'(QUEUE_SIZE));
   assign empty_s = (count_q == {CW{1'b0}});
   assign key_f_s = idle_s ? i_node_f : rep_f_q;
   assign new_e_s = {1'b1, key_f_s, (idle_s ? i_node_xy : rep_xy_q)};

   assign acc_wrt_s  = idle_s && i_valid && i_wrt && !i_read && !i_rep && !full_s;
   assign acc_read_s = idle_s && i_valid && i_read && !i_wrt && !i_rep && !empty_s;
   assign acc_pp_s   = idle_s && i_valid && i_wrt && i_read && !i_rep && !empty_s;
   assign acc_rep_s  = idle_s && i_valid && i_rep && !i_wrt && !i_read;

   for (genvar g = 0; g < N; g++) begin : g_slot
      logic [EW-1:0] up_s, dn_s;
      if (g == N - 1) begin : g_last
         assign up_s = '0;
      end else begin : g_mid
         assign up_s = ent_s[g+1];
      end
      if (g == 0) begin : g_first
         assign dn_s = '0;
      end else begin : g_rest
         assign dn_s = ent_s[g-1];
      end
      open_list_pq_slot #(
         .DATA_WIDTH (DATA_WIDTH),
         .XY_W       (XY_W)
      ) u_slot (
         .CLK          (CLK),
         .RSTn         (RSTn),
         .load_i       (load_s[g]),
         .shift_up_i   (sup_s[g]),
         .shift_down_i (sdn_s[g]),
         .new_i        (new_e_s),
         .up_i         (up_s),
         .down_i       (dn_s),
         .key_f_i      (key_f_s),
         .key_xy_i     (rep_xy_q),
         .entry_o      (ent_s[g]),
         .le_o         (le_s[g]),
         .match_o      (match_s[g])
      );
   end

   // Insert positions (plain and after head removal) and first-match removal vectors.
   always_comb begin
      logic hit;
      hit      = 1'b0;
      rm_s     = '0;
      rm_ge_s  = '0;
      le_nx_s  = {1'b0, le_s[N-1:1]};
      pos_s    = ~le_s & {le_s[N-2:0], 1'b1};
      after_s  = ~le_s & ~pos_s;
      pp_pos_s = ~le_nx_s & {le_nx_s[N-2:0], 1'b1};
      for (int i = 0; i < N; i++) begin
         rm_s[i]    = match_s[i] && !hit;
         hit        = hit || match_s[i];
         rm_ge_s[i] = hit;
      end
   end

   assign any_match_s = |match_s;
   // Stored f above the latched key means the decrease-key actually lowers it.
   assign rm_do_s     = |(rm_s & ~le_s);

   // Command sequencing, slot controls, count and replace FSM next state.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rep_f_d   = rep_f_q;
      rep_xy_d  = rep_xy_q;
      rep_ins_d = rep_ins_q;
      ovf_d     = 1'b0;
      load_s    = '0;
      sup_s     = '0;
      sdn_s     = '0;
      case (state_q)
         IDLE: begin
            if (acc_rep_s) begin
               state_d  = REP_SEARCH;
               rep_f_d  = i_node_f;
               rep_xy_d = i_node_xy;
            end else if (acc_pp_s) begin
               sup_s  = le_nx_s;
               load_s = pp_pos_s;
            end else if (acc_wrt_s) begin
               load_s  = pos_s;
               sdn_s   = after_s;
               count_d = count_q + CW'(1);
            end else if (acc_read_s) begin
               sup_s   = '1;
               count_d = count_q - CW'(1);
            end else begin
               state_d = IDLE;
            end
         end
         REP_SEARCH: begin
            state_d   = REP_INSERT;
            rep_ins_d = rm_do_s || !any_match_s;
            if (rm_do_s) begin
               sup_s   = rm_ge_s;
               count_d = count_q - CW'(1);
            end else begin
               sup_s = '0;
            end
         end
         REP_INSERT: begin
            state_d = IDLE;
            if (rep_ins_q && full_s) begin
               ovf_d = 1'b1;
            end else if (rep_ins_q) begin
               load_s  = pos_s;
               sdn_s   = after_s;
               count_d = count_q + CW'(1);
            end else begin
               ovf_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= IDLE;
         count_q   <= '0;
         rep_f_q   <= '0;
         rep_xy_q  <= '0;
         rep_ins_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rep_f_q   <= rep_f_d;
         rep_xy_q  <= rep_xy_d;
         rep_ins_q <= rep_ins_d;
         ovf_q     <= ovf_d;
      end
   end

   assign o_full      = full_s;
   assign o_empty     = empty_s;
   assign o_valid     = !empty_s;
   assign o_count     = count_q;
   assign o_overflow  = ovf_q;
   assign o_ready_enq = idle_s && !full_s;
   assign o_ready_deq = idle_s && !empty_s;
   assign o_ready_rep = idle_s;
   assign o_node_f    = ent_s[0][EW-1] ? ent_s[0][EW-2:XY_W] : '0;
   assign o_node_xy   = ent_s[0][EW-1] ? ent_s[0][XY_W-1:0] : '0;

endmodule

// File: tb/tb_open_list_pq.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_open_list_pq;

   localparam int QS  = 4;
   localparam int DW  = 32;
   localparam int XYW = 8;
   localparam int CW  = 3;

   logic           CLK = 1'b0;
   logic           RSTn;
   logic           i_valid, i_wrt, i_read, i_rep;
   logic [DW-1:0]  i_node_f;
   logic [XYW-1:0] i_node_xy;
   logic           o_ready_enq, o_ready_deq, o_ready_rep, o_full, o_empty, o_valid, o_overflow;
   logic [DW-1:0]  o_node_f;
   logic [XYW-1:0] o_node_xy;
   logic [CW-1:0]  o_count;

   always #5 CLK = ~CLK;

   open_list_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MAP_WIDTH(16), .MAP_HEIGHT(16)) dut (
      .CLK(CLK), .RSTn(RSTn), .i_valid(i_valid), .i_wrt(i_wrt), .i_read(i_read), .i_rep(i_rep),
      .i_node_f(i_node_f), .i_node_xy(i_node_xy), .o_ready_enq(o_ready_enq),
      .o_ready_deq(o_ready_deq), .o_ready_rep(o_ready_rep), .o_full(o_full), .o_empty(o_empty),
      .o_valid(o_valid), .o_node_f(o_node_f), .o_node_xy(o_node_xy), .o_count(o_count),
      .o_overflow(o_overflow)
   );

   int             n_tests = 0;
   int             n_fail  = 0;
   logic [DW-1:0]  mf[$];
   logic [XYW-1:0] mxy[$];
   int             busy;
   logic [DW-1:0]  lf;
   logic [XYW-1:0] lxy;
   logic           movf;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void m_insert(input logic [DW-1:0] f, input logic [XYW-1:0] xy);
      int p;
      p = 0;
      while (p < mf.size() && mf[p] <= f) p++;
      mf.insert(p, f);
      mxy.insert(p, xy);
   endfunction

   function automatic void m_replace();
      int idx;
      idx  = -1;
      movf = 1'b0;
      for (int i = 0; i < mf.size(); i++) begin
         if (idx < 0 && mxy[i] == lxy) idx = i;
      end
      if (idx >= 0) begin
         if (lf < mf[idx]) begin
            mf.delete(idx);
            mxy.delete(idx);
            m_insert(lf, lxy);
         end
      end else if (mf.size() == QS) begin
         movf = 1'b1;
      end else begin
         m_insert(lf, lxy);
      end
   endfunction

   task automatic m_check(input string tag);
      int sz;
      sz = mf.size();
      if (busy == 0) begin
         chk({tag, ":count"}, 64'(o_count), 64'(sz));
         chk({tag, ":head_f"}, 64'(o_node_f), 64'((sz > 0) ? mf[0] : '0));
         chk({tag, ":head_xy"}, 64'(o_node_xy), 64'((sz > 0) ? mxy[0] : '0));
         chk({tag, ":flags"},
             64'({o_full, o_empty, o_valid, o_ready_enq, o_ready_deq, o_ready_rep, o_overflow}),
             64'({sz == QS, sz == 0, sz != 0, sz != QS, sz != 0, 1'b1, movf}));
      end else begin
         chk({tag, ":busy_rdy"}, 64'({o_ready_enq, o_ready_deq, o_ready_rep, o_overflow}), 64'(0));
      end
   endtask

   task automatic step(input logic v, input logic w, input logic r, input logic rp,
                       input logic [DW-1:0] f, input logic [XYW-1:0] xy, input string tag);
      int sz;
      sz = mf.size();
      i_valid = v; i_wrt = w; i_read = r; i_rep = rp; i_node_f = f; i_node_xy = xy;
      @(posedge CLK);
      #1;
      if (busy > 0) begin
         busy--;
         if (busy == 0) m_replace();
         else movf = 1'b0;
      end else begin
         movf = 1'b0;
         if (v && rp && !w && !r) begin
            busy = 2; lf = f; lxy = xy;
         end else if (v && !rp && w && r && sz > 0) begin
            void'(mf.pop_front()); void'(mxy.pop_front()); m_insert(f, xy);
         end else if (v && !rp && w && !r && sz < QS) begin
            m_insert(f, xy);
         end else if (v && !rp && !w && r && sz > 0) begin
            void'(mf.pop_front()); void'(mxy.pop_front());
         end
      end
      i_valid = 1'b0;
      m_check(tag);
   endtask

   task automatic enq(input logic [DW-1:0] f, input logic [XYW-1:0] xy);
      step(1'b1, 1'b1, 1'b0, 1'b0, f, xy, "enq");
   endtask

   task automatic deq();
      step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, "deq");
   endtask

   task automatic rep(input logic [DW-1:0] f, input logic [XYW-1:0] xy);
      step(1'b1, 1'b0, 1'b0, 1'b1, f, xy, "rep");
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "rep_s");
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "rep_i");
   endtask

   task automatic drain();
      while (mf.size() > 0) deq();
   endtask

   initial begin
      RSTn = 1'b0; i_valid = 1'b0; i_wrt = 1'b0; i_read = 1'b0; i_rep = 1'b0;
      i_node_f = '0; i_node_xy = '0; busy = 0; movf = 1'b0; lf = '0; lxy = '0;
      #12;
      m_check("reset");
      RSTn = 1'b1;

      enq(32'd5, 8'h01); enq(32'd2, 8'h02); enq(32'd3, 8'h03); enq(32'd7, 8'h04);
      chk("t1_head0", 64'(o_node_f), 64'd2);
      deq(); chk("t1_head1", 64'(o_node_f), 64'd3);
      deq(); chk("t1_head2", 64'(o_node_f), 64'd5);
      deq(); chk("t1_head3", 64'(o_node_f), 64'd7);
      deq(); chk("t1_empty", 64'(o_empty), 64'd1);

      enq(32'd1, 8'h10); enq(32'd2, 8'h20); enq(32'd3, 8'h30); enq(32'd4, 8'h40);
      chk("t2_full", 64'({o_full, o_ready_enq}), 64'b10);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 8'h55, "t2_rep");
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "t2_s");
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "t2_i");
      chk("t2_ovf", 64'({o_overflow, o_count}), 64'({1'b1, 3'd4}));
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "t2_idle");
      chk("t2_ovf_clr", 64'(o_overflow), 64'd0);
      drain();

      enq(32'd9, 8'h11); enq(32'd4, 8'h22);
      rep(32'd3, 8'h11);
      chk("t3_dec", 64'({o_node_f, o_node_xy, o_count}), 64'({32'd3, 8'h11, 3'd2}));
      rep(32'd8, 8'h22);
      chk("t3_nochg", 64'({o_node_f, o_count}), 64'({32'd3, 3'd2}));
      drain();

      enq(32'd6, 8'h01); enq(32'd6, 8'h02); enq(32'd6, 8'h03);
      chk("t4_tie0", 64'(o_node_xy), 64'h01);
      deq(); chk("t4_tie1", 64'(o_node_xy), 64'h02);
      deq(); chk("t4_tie2", 64'(o_node_xy), 64'h03);
      deq();

      enq(32'd2, 8'h02); enq(32'd5, 8'h05);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'd1, 8'h01, "t5_pp");
      chk("t5_pp", 64'({o_node_f, o_count}), 64'({32'd1, 3'd2}));
      deq(); chk("t5_next", 64'(o_node_f), 64'd5);
      drain();

      enq(32'd4, 8'h05);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 8'h05, "t6_rep");
      RSTn = 1'b0;
      #1;
      mf.delete(); mxy.delete(); busy = 0; movf = 1'b0;
      m_check("t6_rst");
      #2;
      RSTn = 1'b1;
      enq(32'd10, 8'h07);
      chk("t6_after", 64'({o_node_f, o_count}), 64'({32'd10, 3'd1}));
      drain();

      for (int k = 0; k < 600; k++) begin
         logic v, w, r, rp;
         v  = ($urandom_range(0, 7) != 0);
         w  = $urandom_range(0, 1) == 1;
         r  = $urandom_range(0, 2) == 0;
         rp = ($urandom_range(0, 4) == 0);
         step(v, w, r, rp, 32'($urandom_range(0, 15)), 8'($urandom_range(0, 7)), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
